smart_counter_p: RTL and testbench

Parametrised successor to the team's 8-bit load/enable counter. Adds the following:
- configurable width and modulus
- up/down counting with programmable step
- wrap or saturate overflow mode
- enable prescaler
- wrap/saturate event pulses and a terminal-count flag

Intended as the general-purpose event/timebase counter for control datapaths; a single clock domain throughout.

---
 rtl/smart_counter_p.sv | 140 ++++++++++++++
 tb/tb_smart_counter_p.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_counter_p.sv
// -----------------------------------------------------------------------------
// smart_counter_p
// General-purpose event/timebase counter for control datapaths: parametrised
// width and modulus, up/down counting with a programmable step, wrap or
// saturate behaviour at the bounds, an enable prescaler, registered
// wrap/saturate event pulses and a combinational terminal-count flag.
//
// Ports
//   clk       in   rising-edge clock, single domain
//   rst       in   synchronous active-high reset
//   load      in   load data_in (clamped to MAX_VAL) this cycle
//   enable    in   counting enable, gated by the prescaler
//   up_dn     in   1 = count up, 0 = count down
//   sat_mode  in   1 = saturate at the bounds, 0 = wrap modulo MAX_VAL+1
//   step      in   [WIDTH]       magnitude per tick (clamped to MAX_VAL)
//   prescale  in   [PRESCALE_W]  one tick every prescale+1 enabled cycles
//   data_in   in   [WIDTH]       load value
//   count     out  [WIDTH]       registered count, never above MAX_VAL
//   wrap      out  1-cycle pulse: the last tick wrapped around a bound
//   sat_hit   out  1-cycle pulse: the last tick was clamped at a bound
//   tc        out  terminal count for the current direction
// -----------------------------------------------------------------------------
module smart_counter_p #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_VAL    = 255,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic [WIDTH-1:0]      step,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      count,
  output logic                  wrap,
  output logic                  sat_hit,
  output logic                  tc
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);

  logic [WIDTH-1:0]      r_count;
  logic                  r_wrap;
  logic                  r_sat_hit;
  logic [PRESCALE_W-1:0] r_pre_cnt;

  logic                  w_pre_match;
  logic                  w_tick;
  logic [WIDTH-1:0]      w_step_eff;
  logic [WIDTH-1:0]      w_load_val;
  logic [WIDTH:0]        w_sum_up;
  logic [WIDTH-1:0]      w_wrap_up;
  logic [WIDTH-1:0]      w_wrap_dn;
  logic [WIDTH-1:0]      w_next_count;
  logic                  w_next_wrap;
  logic                  w_next_sat;

  // A prescale reduced below the current pre_cnt is not caught here; the
  // prescaler keeps counting and matches again after it rolls over.
  assign w_pre_match = (r_pre_cnt == prescale);
  assign w_tick      = enable && w_pre_match;

  assign w_step_eff  = (step > MAX_CNT) ? MAX_CNT : step;
  assign w_load_val  = (data_in > MAX_CNT) ? MAX_CNT : data_in;

  // The up sum needs one extra bit so count+step cannot overflow before the
  // comparison against MAX_VAL.
  assign w_sum_up    = {1'b0, r_count} + {1'b0, w_step_eff};

  // Both wrap results are rearranged so that every intermediate value stays
  // in [0, MAX_VAL], allowing WIDTH-bit arithmetic:
  //   up:   count+s-(MAX+1) = count-(MAX-s)-1, valid because count+s > MAX
  //   down: count+(MAX+1)-s = MAX-(s-count-1), valid because s > count
  assign w_wrap_up   = r_count - (MAX_CNT - w_step_eff) - 1'b1;
  assign w_wrap_dn   = MAX_CNT - (w_step_eff - r_count - 1'b1);

  // NOTE: every output of a combinational block gets a default before any
  // branch, so that no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    w_next_sat   = 1'b0;
    if (w_tick) begin
      if (up_dn) begin
        if (w_sum_up <= MAX_EXT) begin
          w_next_count = w_sum_up[WIDTH-1:0];
        end else if (sat_mode) begin
          w_next_count = MAX_CNT;
          w_next_sat   = 1'b1;
        end else begin
          w_next_count = w_wrap_up;
          w_next_wrap  = 1'b1;
        end
      end else begin
        if (r_count >= w_step_eff) begin
          w_next_count = r_count - w_step_eff;
        end else if (sat_mode) begin
          w_next_count = '0;
          w_next_sat   = 1'b1;
        end else begin
          w_next_count = w_wrap_dn;
          w_next_wrap  = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_sat_hit <= 1'b0;
      r_pre_cnt <= '0;
    end else if (load) begin
      r_count   <= w_load_val;
      r_wrap    <= 1'b0;
      r_sat_hit <= 1'b0;
      r_pre_cnt <= '0;
    end else begin
      if (enable) begin
        r_pre_cnt <= w_pre_match ? '0 : r_pre_cnt + 1'b1;
      end
      r_count   <= w_next_count;
      r_wrap    <= w_next_wrap;
      r_sat_hit <= w_next_sat;
    end
  end

  assign count   = r_count;
  assign wrap    = r_wrap;
  assign sat_hit = r_sat_hit;
  assign tc      = up_dn ? (r_count == MAX_CNT) : (r_count == '0);

endmodule

// File: tb/tb_smart_counter_p.sv
// -----------------------------------------------------------------------------
// tb_smart_counter_p
// Directed bench for smart_counter_p. Two instances share all inputs: u_dut
// uses the default parameters (modulus 256), u_dut99 uses MAX_VAL=99. Every
// scenario starts from a load or reset, so each instance has a known state.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_smart_counter_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       enable;
  logic       up_dn;
  logic       sat_mode;
  logic [7:0] step;
  logic [3:0] prescale;
  logic [7:0] data_in;

  logic [7:0] count_a;
  logic       wrap_a;
  logic       sat_a;
  logic       tc_a;
  logic [7:0] count_b;
  logic       wrap_b;
  logic       sat_b;
  logic       tc_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  smart_counter_p u_dut (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up_dn(up_dn),
    .sat_mode(sat_mode), .step(step), .prescale(prescale), .data_in(data_in),
    .count(count_a), .wrap(wrap_a), .sat_hit(sat_a), .tc(tc_a)
  );

  smart_counter_p #(.WIDTH(8), .MAX_VAL(99), .PRESCALE_W(4)) u_dut99 (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up_dn(up_dn),
    .sat_mode(sat_mode), .step(step), .prescale(prescale), .data_in(data_in),
    .count(count_b), .wrap(wrap_b), .sat_hit(sat_b), .tc(tc_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a value with counting disabled; leaves load low afterwards.
  task automatic do_load(input logic [7:0] v);
    load    = 1'b1;
    enable  = 1'b0;
    data_in = v;
    tick();
    load    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({count_a, wrap_a, sat_a} !== {8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_a: count/wrap/sat=%h/%b/%b expected 00/0/0", count_a, wrap_a, sat_a);
    end
    n_vec++;
    if ({count_b, wrap_b, sat_b} !== {8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_b: count/wrap/sat=%h/%b/%b expected 00/0/0", count_b, wrap_b, sat_b);
    end
    n_vec++;
    if (tc_a !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tc_down: tc=%b expected 1", tc_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_count();
    logic [7:0] exp_a;
    do_load(8'h55);
    n_vec++;
    if (count_a !== 8'h55) begin
      n_err++;
      $display("FAIL load_55: count=%h expected 55", count_a);
    end
    enable   = 1'b1;
    up_dn    = 1'b1;
    step     = 8'd1;
    prescale = 4'd0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_a = 8'h55 + 8'(i);
      n_vec++;
      if (count_a !== exp_a) begin
        n_err++;
        $display("FAIL count_up_%0d: count=%h expected %h", i, count_a, exp_a);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap_default();
    sat_mode = 1'b0;
    prescale = 4'd0;
    do_load(8'hF0);
    enable = 1'b1;
    up_dn  = 1'b1;
    step   = 8'd8;
    tick();
    n_vec++;
    if ({count_a, wrap_a} !== {8'hF8, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_up_1: count/wrap=%h/%b expected f8/0", count_a, wrap_a);
    end
    tick();
    n_vec++;
    if ({count_a, wrap_a, sat_a} !== {8'h00, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_up_2: count/wrap/sat=%h/%b/%b expected 00/1/0", count_a, wrap_a, sat_a);
    end
    up_dn = 1'b0;
    step  = 8'd1;
    tick();
    n_vec++;
    if ({count_a, wrap_a} !== {8'hFF, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_down: count/wrap=%h/%b expected ff/1", count_a, wrap_a);
    end
    enable = 1'b0;
    tick();
    n_vec++;
    if ({count_a, wrap_a} !== {8'hFF, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_pulse_end: count/wrap=%h/%b expected ff/0", count_a, wrap_a);
    end
    up_dn = 1'b1;
    #1;
    n_vec++;
    if (tc_a !== 1'b1) begin
      n_err++;
      $display("FAIL tc_up_max: tc=%b expected 1", tc_a);
    end
  endtask

  task automatic test_max99();
    sat_mode = 1'b0;
    up_dn    = 1'b1;
    prescale = 4'd0;
    do_load(8'd200);
    n_vec++;
    if ({count_b, tc_b} !== {8'd99, 1'b1}) begin
      n_err++;
      $display("FAIL m99_load_clamp: count/tc=%0d/%b expected 99/1", count_b, tc_b);
    end
    step   = 8'd5;
    enable = 1'b1;
    tick();
    n_vec++;
    if ({count_b, wrap_b} !== {8'd4, 1'b1}) begin
      n_err++;
      $display("FAIL m99_wrap_up: count/wrap=%0d/%b expected 4/1", count_b, wrap_b);
    end
    // Step above MAX_VAL is clamped to 99: 50+99-100 = 49.
    do_load(8'd50);
    step   = 8'd200;
    enable = 1'b1;
    tick();
    n_vec++;
    if ({count_b, wrap_b} !== {8'd49, 1'b1}) begin
      n_err++;
      $display("FAIL m99_step_clamp: count/wrap=%0d/%b expected 49/1", count_b, wrap_b);
    end
    // Landing exactly on MAX_VAL is not a clamp.
    sat_mode = 1'b1;
    do_load(8'd94);
    step   = 8'd5;
    enable = 1'b1;
    tick();
    n_vec++;
    if ({count_b, sat_b} !== {8'd99, 1'b0}) begin
      n_err++;
      $display("FAIL m99_exact_max: count/sat=%0d/%b expected 99/0", count_b, sat_b);
    end
    do_load(8'd97);
    enable = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_vec++;
      if ({count_b, sat_b, wrap_b} !== {8'd99, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL m99_sat_up_%0d: count/sat/wrap=%0d/%b/%b expected 99/1/0", i, count_b, sat_b, wrap_b);
      end
    end
    enable = 1'b0;
    tick();
    n_vec++;
    if ({count_b, sat_b} !== {8'd99, 1'b0}) begin
      n_err++;
      $display("FAIL m99_sat_pulse_end: count/sat=%0d/%b expected 99/0", count_b, sat_b);
    end
    do_load(8'd2);
    up_dn  = 1'b0;
    enable = 1'b1;
    tick();
    n_vec++;
    if ({count_b, sat_b, tc_b} !== {8'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL m99_sat_down: count/sat/tc=%0d/%b/%b expected 0/1/1", count_b, sat_b, tc_b);
    end
    enable   = 1'b0;
    sat_mode = 1'b0;
  endtask

  task automatic test_prescale();
    logic [7:0] exp_a;
    prescale = 4'd3;
    up_dn    = 1'b1;
    step     = 8'd1;
    sat_mode = 1'b0;
    do_load(8'd0);
    enable = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      exp_a = 8'(i / 4);
      n_vec++;
      if (count_a !== exp_a) begin
        n_err++;
        $display("FAIL prescale_cyc%0d: count=%0d expected %0d", i, count_a, exp_a);
      end
    end
    // pre_cnt is 2 here; two disabled cycles push the next tick from edge 16 to 18.
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    n_vec++;
    if (count_a !== 8'd3) begin
      n_err++;
      $display("FAIL prescale_paused_hold: count=%0d expected 3", count_a);
    end
    tick();
    n_vec++;
    if (count_a !== 8'd4) begin
      n_err++;
      $display("FAIL prescale_paused_tick: count=%0d expected 4", count_a);
    end
    enable = 1'b0;
  endtask

  task automatic test_load_priority();
    prescale = 4'd0;
    up_dn    = 1'b1;
    step     = 8'd1;
    load     = 1'b1;
    enable   = 1'b1;
    data_in  = 8'h10;
    tick();
    n_vec++;
    if (count_a !== 8'h10) begin
      n_err++;
      $display("FAIL load_and_enable: count=%h expected 10", count_a);
    end
    load = 1'b0;
    tick();
    n_vec++;
    if (count_a !== 8'h11) begin
      n_err++;
      $display("FAIL after_load_enable: count=%h expected 11", count_a);
    end
    rst     = 1'b1;
    load    = 1'b1;
    data_in = 8'h33;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    n_vec++;
    if (count_a !== 8'h00) begin
      n_err++;
      $display("FAIL rst_over_load: count=%h expected 00", count_a);
    end
    enable = 1'b0;
  endtask

  task automatic test_step_zero();
    prescale = 4'd0;
    up_dn    = 1'b1;
    sat_mode = 1'b0;
    do_load(8'hFF);
    step   = 8'd0;
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if ({count_a, wrap_a, sat_a} !== {8'hFF, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL step_zero_%0d: count/wrap/sat=%h/%b/%b expected ff/0/0", i, count_a, wrap_a, sat_a);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_rst_mid_prescale();
    logic [7:0] exp_a;
    prescale = 4'd7;
    up_dn    = 1'b1;
    step     = 8'd1;
    do_load(8'h40);
    enable = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (count_a !== 8'h00) begin
      n_err++;
      $display("FAIL rst_mid_prescale: count=%h expected 00", count_a);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_a = (i == 8) ? 8'd1 : 8'd0;
      n_vec++;
      if (count_a !== exp_a) begin
        n_err++;
        $display("FAIL post_rst_cyc%0d: count=%0d expected %0d", i, count_a, exp_a);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    enable   = 1'b0;
    up_dn    = 1'b0;
    sat_mode = 1'b0;
    step     = 8'd0;
    prescale = 4'd0;
    data_in  = 8'd0;
    #1;
    test_reset();
    test_load_count();
    test_wrap_default();
    test_max99();
    test_prescale();
    test_load_priority();
    test_step_zero();
    test_rst_mid_prescale();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
